// File: rtl/wb_burst_monitor.sv
// wb_burst_monitor: passive checker for the core's Wishbone master port.
// Shadows the IDLE/BURST/WAIT_ACK master FSM and logs protocol errors.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_wb_cyc/stb/ack observed Wishbone handshake
//   i_burst          with cyc&stb at cycle start: BURST_LEN-beat burst
//   i_extra_write    another write is chained after the final beat
//   i_clr            clear sticky flags and error counter
//   o_state          shadow state (0 IDLE, 1 BURST, 2 WAIT_ACK)
//   o_beat           acks received in the current burst
//   o_err_ack_idle   sticky: ack seen while IDLE
//   o_err_abort      sticky: cyc dropped mid-transfer
//   o_err_timeout    sticky: dwell counter expired
//   o_err_pulse      one-cycle pulse per error event
//   o_err_count      saturating error event count

module wb_burst_monitor #(
   parameter int unsigned BURST_LEN       = 4,
   parameter int unsigned TIMEOUT         = 1000,
   parameter bit          IDLE_TIMEOUT_EN = 1'b0,
   parameter int unsigned ERR_CNT_W       = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_wb_cyc,
   input  logic                 i_wb_stb,
   input  logic                 i_wb_ack,
   input  logic                 i_burst,
   input  logic                 i_extra_write,
   input  logic                 i_clr,
   output logic [1:0]           o_state,
   output logic [3:0]           o_beat,
   output logic                 o_err_ack_idle,
   output logic                 o_err_abort,
   output logic                 o_err_timeout,
   output logic                 o_err_pulse,
   output logic [ERR_CNT_W-1:0] o_err_count
);

   localparam int unsigned DW = $clog2(TIMEOUT + 1);

   // Beat value whose ack completes all but the final beat.
   localparam logic [3:0] PENULT_BEAT = 4'(BURST_LEN - 2);

   localparam logic [DW-1:0] DWELL_LAST = DW'(TIMEOUT - 1);

   localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
   localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [3:0]      beat_q;
   logic [3:0]      beat_d;
   logic [DW-1:0]   dwell_q;
   logic [DW-1:0]   dwell_d;

   logic            ack_idle;
   logic            abort;
   logic            timeout;
   logic            err_any;
   logic            dwell_en;

   logic            ack_idle_q;
   logic            abort_q;
   logic            timeout_q;
   logic            pulse_q;
   logic [ERR_CNT_W-1:0] count_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         dwell_q <= dwell_d;
      end
   end

   assign dwell_en = (state_q != S_IDLE) || IDLE_TIMEOUT_EN;

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      dwell_d  = dwell_q;
      ack_idle = 1'b0;
      abort    = 1'b0;
      timeout  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_wb_ack) begin
               ack_idle = 1'b1;
            end else if (i_wb_cyc && i_wb_stb) begin
               if (i_burst) begin
                  state_d = S_BURST;
                  beat_d  = '0;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_BURST: begin
            // A dropped cyc wins over a same-edge ack.
            if (!i_wb_cyc) begin
               abort   = 1'b1;
               state_d = S_IDLE;
               beat_d  = '0;
            end else if (i_wb_ack) begin
               beat_d = beat_q + 4'd1;
               if (beat_q == PENULT_BEAT) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc) begin
               abort   = 1'b1;
               state_d = S_IDLE;
               beat_d  = '0;
            end else if (i_wb_ack) begin
               beat_d = '0;
               if (!i_extra_write) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            beat_d  = '0;
         end
      endcase

      // Dwell tracks cycles without progress; expiring it forces
      // the shadow FSM back to IDLE (a no-op when already IDLE).
      if ((state_d != state_q) || i_wb_ack || !dwell_en) begin
         dwell_d = '0;
      end else if (dwell_q == DWELL_LAST) begin
         timeout = 1'b1;
         dwell_d = '0;
         state_d = S_IDLE;
         beat_d  = '0;
      end else begin
         dwell_d = dwell_q + DW'(1);
      end
   end

   assign err_any = ack_idle || abort || timeout;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ack_idle_q <= 1'b0;
         abort_q    <= 1'b0;
         timeout_q  <= 1'b0;
         pulse_q    <= 1'b0;
         count_q    <= '0;
      end else begin
         pulse_q <= err_any;
         if (i_clr) begin
            // A clear never hides an error arriving on the same edge.
            ack_idle_q <= ack_idle;
            abort_q    <= abort;
            timeout_q  <= timeout;
            count_q    <= err_any ? CNT_ONE : '0;
         end else begin
            ack_idle_q <= ack_idle_q || ack_idle;
            abort_q    <= abort_q || abort;
            timeout_q  <= timeout_q || timeout;
            if (err_any && (count_q != CNT_MAX)) begin
               count_q <= count_q + CNT_ONE;
            end
         end
      end
   end

   assign o_state        = state_q;
   assign o_beat         = beat_q;
   assign o_err_ack_idle = ack_idle_q;
   assign o_err_abort    = abort_q;
   assign o_err_timeout  = timeout_q;
   assign o_err_pulse    = pulse_q;
   assign o_err_count    = count_q;

endmodule

// File: tb/tb_wb_burst_monitor.sv
// tb_wb_burst_monitor: directed bench for wb_burst_monitor.
// BURST_LEN=4, TIMEOUT=10, ERR_CNT_W=2, IDLE timeout disabled.

module tb_wb_burst_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       cyc;
   logic       stb;
   logic       ack;
   logic       burst;
   logic       extra;
   logic       clr;
   logic [1:0] state;
   logic [3:0] beat;
   logic       e_ai;
   logic       e_ab;
   logic       e_to;
   logic       pulse;
   logic [1:0] cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_burst_monitor #(
      .BURST_LEN(4),
      .TIMEOUT(10),
      .IDLE_TIMEOUT_EN(1'b0),
      .ERR_CNT_W(2)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_wb_cyc(cyc),
      .i_wb_stb(stb),
      .i_wb_ack(ack),
      .i_burst(burst),
      .i_extra_write(extra),
      .i_clr(clr),
      .o_state(state),
      .o_beat(beat),
      .o_err_ack_idle(e_ai),
      .o_err_abort(e_ab),
      .o_err_timeout(e_to),
      .o_err_pulse(pulse),
      .o_err_count(cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // fl = {ack_idle, abort, timeout}
   task automatic expect_out(input string tag, input logic [1:0] st,
                             input logic [3:0] bt, input logic [2:0] fl,
                             input logic pu, input logic [1:0] cn);
      checks++;
      assert (state === st) else begin
         errors++;
         $error("FAIL %s.state observed %0d expected %0d", tag, state, st);
      end
      checks++;
      assert (beat === bt) else begin
         errors++;
         $error("FAIL %s.beat observed %0d expected %0d", tag, beat, bt);
      end
      checks++;
      assert ({e_ai, e_ab, e_to} === fl) else begin
         errors++;
         $error("FAIL %s.flags observed %b expected %b", tag,
                {e_ai, e_ab, e_to}, fl);
      end
      checks++;
      assert (pulse === pu) else begin
         errors++;
         $error("FAIL %s.pulse observed %b expected %b", tag, pulse, pu);
      end
      checks++;
      assert (cnt === cn) else begin
         errors++;
         $error("FAIL %s.count observed %0d expected %0d", tag, cnt, cn);
      end
   endtask

   initial begin
      rst   = 1'b1;
      cyc   = 1'b0;
      stb   = 1'b0;
      ack   = 1'b0;
      burst = 1'b0;
      extra = 1'b0;
      clr   = 1'b0;
      tick();
      tick();
      expect_out("reset", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);
      rst = 1'b0;

      // normal 4-beat burst, acks spaced two cycles apart
      cyc = 1'b1; stb = 1'b1; burst = 1'b1;
      tick();
      expect_out("nb_start", 2'd1, 4'd0, 3'b000, 1'b0, 2'd0);
      burst = 1'b0;
      tick();
      expect_out("nb_gap0", 2'd1, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b1;
      tick();
      expect_out("nb_ack1", 2'd1, 4'd1, 3'b000, 1'b0, 2'd0);
      ack = 1'b0;
      tick();
      ack = 1'b1;
      tick();
      expect_out("nb_ack2", 2'd1, 4'd2, 3'b000, 1'b0, 2'd0);
      ack = 1'b0;
      tick();
      ack = 1'b1;
      tick();
      expect_out("nb_ack3", 2'd2, 4'd3, 3'b000, 1'b0, 2'd0);
      ack = 1'b0;
      tick();
      expect_out("nb_wait", 2'd2, 4'd3, 3'b000, 1'b0, 2'd0);
      ack = 1'b1; extra = 1'b0;
      tick();
      expect_out("nb_ack4", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b0; cyc = 1'b0; stb = 1'b0;
      tick();

      // chained single write
      cyc = 1'b1; stb = 1'b1;
      tick();
      expect_out("ch_start", 2'd2, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b1; extra = 1'b1;
      tick();
      expect_out("ch_ack1", 2'd2, 4'd0, 3'b000, 1'b0, 2'd0);
      extra = 1'b0;
      tick();
      expect_out("ch_ack2", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b0; cyc = 1'b0; stb = 1'b0;
      tick();

      // spurious ack in IDLE, then abort at beat 2
      ack = 1'b1;
      tick();
      expect_out("sp_ack", 2'd0, 4'd0, 3'b100, 1'b1, 2'd1);
      ack = 1'b0;
      tick();
      expect_out("sp_after", 2'd0, 4'd0, 3'b100, 1'b0, 2'd1);
      cyc = 1'b1; stb = 1'b1; burst = 1'b1;
      tick();
      burst = 1'b0; ack = 1'b1;
      tick();
      tick();
      expect_out("ab_beat2", 2'd1, 4'd2, 3'b100, 1'b0, 2'd1);
      ack = 1'b1; cyc = 1'b0; stb = 1'b0;
      tick();
      expect_out("ab_drop", 2'd0, 4'd0, 3'b110, 1'b1, 2'd2);
      ack = 1'b0;
      tick();
      expect_out("ab_after", 2'd0, 4'd0, 3'b110, 1'b0, 2'd2);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_out("reset2", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);

      // timeout in WAIT_ACK after 10 dwell cycles
      cyc = 1'b1; stb = 1'b1;
      tick();
      for (int i = 0; i < 9; i++) tick();
      expect_out("to_pre", 2'd2, 4'd0, 3'b000, 1'b0, 2'd0);
      tick();
      expect_out("to_hit", 2'd0, 4'd0, 3'b001, 1'b1, 2'd1);
      cyc = 1'b0; stb = 1'b0;
      tick();
      expect_out("to_after", 2'd0, 4'd0, 3'b001, 1'b0, 2'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      expect_out("clr", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);

      // ack on dwell cycle 9 restarts the dwell count
      cyc = 1'b1; stb = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) tick();
      ack = 1'b1; extra = 1'b1;
      tick();
      expect_out("nt_ack9", 2'd2, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b0; extra = 1'b0;
      tick();
      tick();
      expect_out("nt_hold", 2'd2, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b1;
      tick();
      expect_out("nt_done", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b0; cyc = 1'b0; stb = 1'b0;
      tick();

      // counter saturation at 3, then clear colliding with an error
      ack = 1'b1;
      tick();
      expect_out("sat1", 2'd0, 4'd0, 3'b100, 1'b1, 2'd1);
      tick();
      expect_out("sat2", 2'd0, 4'd0, 3'b100, 1'b1, 2'd2);
      tick();
      expect_out("sat3", 2'd0, 4'd0, 3'b100, 1'b1, 2'd3);
      tick();
      tick();
      expect_out("sat5", 2'd0, 4'd0, 3'b100, 1'b1, 2'd3);
      clr = 1'b1;
      tick();
      expect_out("clr_err", 2'd0, 4'd0, 3'b100, 1'b1, 2'd1);
      clr = 1'b0; ack = 1'b0;
      tick();
      expect_out("clr_after", 2'd0, 4'd0, 3'b100, 1'b0, 2'd1);

      // reset mid-burst at beat 2, then a clean burst
      cyc = 1'b1; stb = 1'b1; burst = 1'b1;
      tick();
      burst = 1'b0; ack = 1'b1;
      tick();
      tick();
      expect_out("rb_beat2", 2'd1, 4'd2, 3'b100, 1'b0, 2'd1);
      ack = 1'b0; rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      tick();
      rst = 1'b0;
      expect_out("rb_reset", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);
      cyc = 1'b1; stb = 1'b1; burst = 1'b1;
      tick();
      expect_out("rb_start", 2'd1, 4'd0, 3'b000, 1'b0, 2'd0);
      burst = 1'b0; ack = 1'b1;
      tick();
      tick();
      tick();
      expect_out("rb_beat3", 2'd2, 4'd3, 3'b000, 1'b0, 2'd0);
      tick();
      expect_out("rb_done", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);
      ack = 1'b0; cyc = 1'b0; stb = 1'b0;
      tick();
      expect_out("rb_idle", 2'd0, 4'd0, 3'b000, 1'b0, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
